find_first_one: RTL and testbench

//  Leading-one detector / priority encoder. Reports the bit position of the most significant '1'
//  in an N-bit input word, plus a valid flag that is set when any bit is set.

---
 rtl/find_first_one_pkg.sv | 43 ++++
 rtl/find_first_one_if.sv | 17 +
 rtl/find_first_one_merge.sv | 19 +
 rtl/find_first_one.sv | 83 ++++++++
 tb/tb_find_first_one.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/find_first_one_pkg.sv
// Shared types, constants and reference model for the leading-one detector.
package ffo_pkg;

  localparam int unsigned FFO_DEFAULT_N = 32;
  localparam int unsigned FFO_MAX_N     = 64;
  localparam int unsigned FFO_MAX_IW    = 6;

  // Result record: any-bit-set flag plus MSB position.
  typedef struct packed {
    logic                  v;
    logic [FFO_MAX_IW-1:0] idx;
  } ffo_res_t;

  // Behavioural leading-one search over the low n bits of x.
  function automatic ffo_res_t ffo_ref(logic [FFO_MAX_N-1:0] x, int n);
    ffo_res_t res;
    res.v   = 1'b0;
    res.idx = '0;
    for (int k = 0; k < n; k++) begin
      if (x[k]) begin
        res.v   = 1'b1;
        res.idx = FFO_MAX_IW'(k);
      end
    end
    return res;
  endfunction

  // First bit of tree level lvl inside the flat valid vector (levels start at 1).
  function automatic int unsigned ffo_v_off(int unsigned lvl, int unsigned p);
    return p - (p >> (lvl - 1));
  endfunction

  // First bit of tree level lvl inside the flat index vector; level k nodes carry k index bits.
  function automatic int unsigned ffo_idx_off(int unsigned lvl, int unsigned p);
    int unsigned off;
    off = 0;
    for (int unsigned k = 1; k < lvl; k++) begin
      off += k * (p >> k);
    end
    return off;
  endfunction

endpackage

// File: rtl/find_first_one_if.sv
// Scan-word in, registered {valid,index} out.
interface find_first_one_if
  import ffo_pkg::*;
#(
  parameter int unsigned N = FFO_DEFAULT_N
);

  localparam int unsigned INDEX_WIDTH = $clog2(N);

  logic [N-1:0]           testVal;
  logic                   valid;
  logic [INDEX_WIDTH-1:0] index;

  modport master (output testVal, input valid, input index);
  modport slave  (input testVal, output valid, output index);

endinterface

// File: rtl/find_first_one_merge.sv
// One node of the leading-one tree: the upper half wins whenever it has a set bit.
module ffo_merge #(
  parameter int unsigned W = 1
) (
  input  logic         hi_v,
  input  logic [W-1:0] hi_idx,
  input  logic         lo_v,
  input  logic [W-1:0] lo_idx,
  output logic         v,
  output logic [W:0]   idx
);

  // Combine the two halves; the new MSB of idx records which half was chosen.
  always_comb begin
    v   = hi_v | lo_v;
    idx = hi_v ? {1'b1, hi_idx} : {1'b0, lo_idx};
  end

endmodule

// File: rtl/find_first_one.sv
// Leading-one detector: position of the most significant set bit, one cycle of latency.
module find_first_one
  import ffo_pkg::*;
#(
  parameter int unsigned N = FFO_DEFAULT_N
) (
  input  logic                  clk,
  input  logic                  reset,
  find_first_one_if.slave       bus
);

  localparam int unsigned INDEX_WIDTH = $clog2(N);
  localparam int unsigned PAD_N       = 1 << INDEX_WIDTH;
  localparam int unsigned V_TOT       = PAD_N - 1;
  localparam int unsigned I_TOT       = ffo_idx_off(INDEX_WIDTH + 1, PAD_N);
  localparam int unsigned V_ROOT      = V_TOT - 1;
  localparam int unsigned I_ROOT      = I_TOT - INDEX_WIDTH;

  logic [PAD_N-1:0]       padded;
  logic [V_TOT-1:0]       v_tree;
  logic [I_TOT-1:0]       idx_tree;

  logic                   valid_d;
  logic                   valid_q;
  logic [INDEX_WIDTH-1:0] index_d;
  logic [INDEX_WIDTH-1:0] index_q;

  // Zero-extend to a power of two; padding bits can never win, so index stays below N.
  assign padded = PAD_N'(bus.testVal);

  // All tree levels live in two flat vectors; level l has PAD_N>>l nodes of l index bits each.
  for (genvar l = 1; l <= int'(INDEX_WIDTH); l++) begin : g_lvl
    localparam int unsigned NODES = PAD_N >> l;
    localparam int unsigned VO    = ffo_v_off(l, PAD_N);
    localparam int unsigned IO    = ffo_idx_off(l, PAD_N);

    if (l == 1) begin : g_leaf
      // Leaves are single bits, so the first level reduces bit pairs directly.
      for (genvar j = 0; j < int'(NODES); j++) begin : g_node
        assign v_tree[VO + j]   = padded[2*j+1] | padded[2*j];
        assign idx_tree[IO + j] = padded[2*j+1];
      end
    end else begin : g_merge
      localparam int unsigned CW  = l - 1;
      localparam int unsigned CVO = ffo_v_off(l - 1, PAD_N);
      localparam int unsigned CIO = ffo_idx_off(l - 1, PAD_N);

      for (genvar j = 0; j < int'(NODES); j++) begin : g_node
        ffo_merge #(
          .W (CW)
        ) u_merge (
          .hi_v   (v_tree[CVO + 2*j + 1]),
          .hi_idx (idx_tree[CIO + (2*j + 1) * CW +: CW]),
          .lo_v   (v_tree[CVO + 2*j]),
          .lo_idx (idx_tree[CIO + (2*j) * CW +: CW]),
          .v      (v_tree[VO + j]),
          .idx    (idx_tree[IO + j * l +: l])
        );
      end
    end
  end

  // Tree root is the next value of the output register.
  always_comb begin
    valid_d = v_tree[V_ROOT];
    index_d = idx_tree[I_ROOT +: INDEX_WIDTH];
  end

  // Output register; reset overrides the incoming word.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      index_q <= '0;
    end else begin
      valid_q <= valid_d;
      index_q <= index_d;
    end
  end

  assign bus.valid = valid_q;
  assign bus.index = index_q;

endmodule

// File: tb/tb_find_first_one.sv
// Scoreboard bench for find_first_one at N = 32, 8, 12 and 64 driven with a shared stimulus word.
module tb_find_first_one;
  import ffo_pkg::*;

  localparam int NDUT = 4;

  typedef struct {
    logic [NDUT-1:0]      ev;
    logic [NDUT-1:0][5:0] ei;
    string                tag;
  } exp_t;

  typedef struct {
    logic [63:0] w;
    logic        r;
    logic        v;
    logic [5:0]  i;
    string       tag;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] stim;

  exp_t        sb[$];
  exp_t        cur;
  int          n_vec = 0;
  int          n_bad = 0;
  logic [NDUT-1:0]      act_v;
  logic [NDUT-1:0][5:0] act_i;

  always #5 clk = ~clk;

  find_first_one_if #(.N(32)) b32 ();
  find_first_one_if #(.N(8))  b8  ();
  find_first_one_if #(.N(12)) b12 ();
  find_first_one_if #(.N(64)) b64 ();

  assign b32.testVal = stim[31:0];
  assign b8.testVal  = stim[7:0];
  assign b12.testVal = stim[11:0];
  assign b64.testVal = stim;

  find_first_one #(.N(32)) u_dut32 (.clk(clk), .reset(reset), .bus(b32));
  find_first_one #(.N(8))  u_dut8  (.clk(clk), .reset(reset), .bus(b8));
  find_first_one #(.N(12)) u_dut12 (.clk(clk), .reset(reset), .bus(b12));
  find_first_one #(.N(64)) u_dut64 (.clk(clk), .reset(reset), .bus(b64));

  function automatic int width_of(int d);
    case (d)
      0:       return 32;
      1:       return 8;
      2:       return 12;
      default: return 64;
    endcase
  endfunction

  // Independent model: scan downward from the top bit of an n-bit word.
  function automatic void tb_ref(input logic [63:0] x, input int n,
                                 output logic v, output logic [5:0] i);
    v = 1'b0;
    i = '0;
    for (int k = n - 1; k >= 0; k--) begin
      if (x[k]) begin
        v = 1'b1;
        i = 6'(k);
        break;
      end
    end
  endfunction

  // Drive one word before the next rising edge and queue what each instance must show after it.
  task automatic drive(input logic [63:0] w, input logic r, input string tag,
                       input logic fix, input logic fv, input logic [5:0] fi);
    exp_t e;
    logic v;
    logic [5:0] i;
    @(negedge clk);
    reset = r;
    stim  = w;
    for (int d = 0; d < NDUT; d++) begin
      if (r) begin
        v = 1'b0;
        i = '0;
      end else begin
        tb_ref(w, width_of(d), v, i);
      end
      e.ev[d] = v;
      e.ei[d] = i;
    end
    if (fix) begin
      e.ev[0] = fv;
      e.ei[0] = fi;
    end
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Check each queued expectation just after the edge that produced it.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      cur   = sb.pop_front();
      act_v = {b64.valid, b12.valid, b8.valid, b32.valid};
      act_i[0] = 6'(b32.index);
      act_i[1] = 6'(b8.index);
      act_i[2] = 6'(b12.index);
      act_i[3] = b64.index;
      for (int d = 0; d < NDUT; d++) begin
        n_vec++;
        if (act_v[d] !== cur.ev[d] || act_i[d] !== cur.ei[d]) begin
          n_bad++;
          $display("FAIL %s N=%0d: got valid=%b index=%0d, expected valid=%b index=%0d",
                   cur.tag, width_of(d), act_v[d], act_i[d], cur.ev[d], cur.ei[d]);
        end
      end
    end
  end

  vec_t tbl[12];

  initial begin
    reset = 1'b1;
    stim  = '0;

    // Expected index/valid columns are for the N=32 instance.
    tbl[0]  = '{64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0, 6'd0,  "reset_ones"};
    tbl[1]  = '{64'h0000_0000_FFFF_FFFF, 1'b0, 1'b1, 6'd31, "post_reset"};
    tbl[2]  = '{64'h0000_0000_0000_0000, 1'b0, 1'b0, 6'd0,  "zero"};
    tbl[3]  = '{64'h0000_0000_0000_0001, 1'b0, 1'b1, 6'd0,  "one"};
    tbl[4]  = '{64'h0000_0000_0001_8000, 1'b0, 1'b1, 6'd16, "mix_18000"};
    tbl[5]  = '{64'h0000_0000_00F0_0F00, 1'b0, 1'b1, 6'd23, "mix_f00f00"};
    tbl[6]  = '{64'h0000_0000_8000_0001, 1'b0, 1'b1, 6'd31, "mix_80000001"};
    tbl[7]  = '{64'h0000_0000_0000_0600, 1'b0, 1'b1, 6'd10, "mix_600"};
    tbl[8]  = '{64'h0000_0000_0000_0800, 1'b0, 1'b1, 6'd11, "n12_msb"};
    tbl[9]  = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 6'd31, "all_ones64"};
    tbl[10] = '{64'h8000_0000_0000_0000, 1'b0, 1'b0, 6'd0,  "above_n32"};
    tbl[11] = '{64'h0000_0000_0000_0000, 1'b0, 1'b0, 6'd0,  "zero_after_ones"};

    for (int t = 0; t < 12; t++) begin
      drive(tbl[t].w, tbl[t].r, tbl[t].tag, 1'b1, tbl[t].v, tbl[t].i);
    end

    for (int k = 0; k < 64; k++) begin
      drive(64'h1 << k, 1'b0, "walk_one", 1'b0, 1'b0, 6'd0);
    end
    for (int k = 0; k < 64; k++) begin
      drive(~(64'h1 << k), 1'b0, "walk_zero", 1'b0, 1'b0, 6'd0);
    end

    // Reset pulse mid-stream, then the first post-reset edge loads normally.
    drive(64'h0000_0000_0000_00F0, 1'b0, "pre_reset",    1'b0, 1'b0, 6'd0);
    drive(64'h0000_0000_0000_00F0, 1'b1, "mid_reset",    1'b0, 1'b0, 6'd0);
    drive(64'h0000_0000_0000_0010, 1'b0, "first_load",   1'b0, 1'b0, 6'd0);
    // Two-cycle reset with changing input, then back-to-back loads.
    drive(64'hFFFF_0000_FFFF_0000, 1'b1, "hold_reset_a", 1'b0, 1'b0, 6'd0);
    drive(64'h0000_FFFF_0000_FFFF, 1'b1, "hold_reset_b", 1'b0, 1'b0, 6'd0);
    drive(64'h0000_0000_0000_0003, 1'b0, "resume_a",     1'b0, 1'b0, 6'd0);
    drive(64'h4000_0000_0000_0000, 1'b0, "resume_b",     1'b0, 1'b0, 6'd0);
    drive(64'h0000_0000_0000_0000, 1'b0, "resume_zero",  1'b0, 1'b0, 6'd0);

    // Random words, shifted to spread the MSB position across all widths.
    for (int n = 0; n < 3000; n++) begin
      drive({$urandom, $urandom} >> $urandom_range(0, 63), 1'b0, "random",
            1'b0, 1'b0, 6'd0);
    end

    for (int t = 0; t < 10 && sb.size() != 0; t++) begin
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending results, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
